// File: rtl/station_if.sv
// Station controller bus: operator/line inputs, actuator outputs,
// batch counters and the exposed FSM state.
//
// Signalling: there is no valid/ready handshake on this bus. The line inputs
// are levels, and station_ctrl samples them on every rising clk edge:
//   - start and stop are held levels.
//   - sensor is already synchronised.
//   - part_ok is valid in the last PROCESS cycle.
// The outputs are decoded from registered state and are stable for a whole
// cycle. The exception is eject, which is a one-cycle pulse.
interface station_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             sensor;
  logic             part_ok;
  logic             motor_on;
  logic             tool_on;
  logic             eject;
  logic             batch_done;
  logic [CNT_W-1:0] count_ok;
  logic [CNT_W-1:0] count_rej;
  logic [2:0]       state;

  // The line or bench drives the inputs and observes everything else.
  modport master (
    output start, stop, sensor, part_ok,
    input  motor_on, tool_on, eject, batch_done, count_ok, count_rej, state
  );

  // The controller side.
  modport slave (
    input  start, stop, sensor, part_ok,
    output motor_on, tool_on, eject, batch_done, count_ok, count_rej, state
  );
endinterface

// File: rtl/station_ctrl.sv
// Assembly-line station controller.
//
// Detects an arriving part from a rising sensor edge and centres it
// (ALIGN, belt running). It then runs the tool with the belt stopped
// (PROCESS) and classifies the part. Finally it waits for the part to leave
// (RELEASE).
//
// Good and rejected parts are counted with saturating counters. The belt
// halts in DONE once BATCH good parts have been produced.
module station_ctrl #(
  parameter int ALIGN_CYCLES = 2,
  parameter int PROC_CYCLES  = 4,
  parameter int BATCH        = 3,
  parameter int CNT_W        = 8
) (
  input logic      clk,
  input logic      reset,
  station_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    ALIGN   = 3'd2,
    PROCESS = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int PMAX = (ALIGN_CYCLES > PROC_CYCLES) ? ALIGN_CYCLES : PROC_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0]    ALIGN_LOAD = PW'(ALIGN_CYCLES - 1);
  localparam logic [PW-1:0]    PROC_LOAD  = PW'(PROC_CYCLES - 1);
  localparam logic [CNT_W-1:0] BATCH_CNT  = CNT_W'(BATCH);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           st;
  logic             sensor_q;
  logic             stop_pend;
  logic [PW-1:0]    phase;
  logic [CNT_W-1:0] count_ok;
  logic [CNT_W-1:0] count_rej;
  logic             eject;
  logic             part_edge;

  // A new part is a rising edge on the synchronised sensor. Only RUN looks at it.
  assign part_edge = bus.sensor & ~sensor_q;

  // Actuator and status outputs decode the state register directly, so they
  // add no latency.
  assign bus.motor_on   = (st == RUN) || (st == ALIGN) || (st == RELEASE);
  assign bus.tool_on    = (st == PROCESS);
  assign bus.batch_done = (st == DONE);
  assign bus.eject      = eject;
  assign bus.count_ok   = count_ok;
  assign bus.count_rej  = count_rej;
  assign bus.state      = st;

  // Station FSM, phase timer, part counters and eject pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      sensor_q  <= 1'b0;
      stop_pend <= 1'b0;
      phase     <= '0;
      count_ok  <= '0;
      count_rej <= '0;
      eject     <= 1'b0;
    end else begin
      sensor_q <= bus.sensor;
      eject    <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.start && !bus.stop) st <= RUN;
        end
        RUN: begin
          if (bus.stop) begin
            st <= IDLE;
          end else if (part_edge) begin
            st    <= ALIGN;
            phase <= ALIGN_LOAD;
          end
        end
        ALIGN: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (phase == '0) begin
            st    <= PROCESS;
            phase <= PROC_LOAD;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        PROCESS: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (phase == '0) begin
            // part_ok is only meaningful in this final tool cycle.
            st <= RELEASE;
            if (bus.part_ok) begin
              if (count_ok != CNT_MAX) count_ok <= count_ok + 1'b1;
            end else begin
              if (count_rej != CNT_MAX) count_rej <= count_rej + 1'b1;
              eject <= 1'b1;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.sensor) begin
            stop_pend <= 1'b0;
            if (count_ok == BATCH_CNT)        st <= DONE;
            else if (stop_pend || bus.stop)   st <= IDLE;
            else                              st <= RUN;
          end else if (bus.stop) begin
            stop_pend <= 1'b1;
          end
        end
        DONE: begin
          if (bus.stop) begin
            st <= IDLE;
          end else if (bus.start) begin
            // A new batch starts from zero. IDLE->RUN keeps the counts.
            count_ok  <= '0;
            count_rej <= '0;
            st        <= RUN;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_station_ctrl.sv
// Bench for station_ctrl with the default parameters.
//
// The main process drives directed part sequences and checks per-cycle
// phase and actuator behaviour. Each part pushes its expected
// {count_ok, count_rej, eject} into exp_q. A monitor pops and compares
// that entry whenever the DUT enters RELEASE.
module tb_station_ctrl;
  localparam int CNT_W = 8;
  localparam int W     = 2 * CNT_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_ALIGN   = 3'd2;
  localparam logic [2:0] S_PROCESS = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic clk = 1'b0;
  logic reset;

  station_if #(.CNT_W(CNT_W)) bus();

  station_ctrl #(
    .ALIGN_CYCLES(2),
    .PROC_CYCLES (4),
    .BATCH       (3),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] m_ok  = '0;
  logic [CNT_W-1:0] m_rej = '0;
  logic [2:0]       prev_state = 3'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare counters and eject on every RELEASE entry.
  always @(negedge clk) begin
    if (!reset && bus.state == S_RELEASE && prev_state != S_RELEASE) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL release_entry unexpected part actual=%h", {bus.count_ok, bus.count_rej, bus.eject});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.count_ok, bus.count_rej, bus.eject} != e) begin
          failures++;
          $display("FAIL release_entry actual=%h expected=%h at %0t",
                   {bus.count_ok, bus.count_rej, bus.eject}, e, $time);
        end
      end
    end
    prev_state = reset ? S_IDLE : bus.state;
  end

  // Run one part through the station.
  //
  // On entry the DUT is in RUN and sensor is low. The task leaves sensor low
  // and takes one step past the cycle in which the sensor drops, so the
  // caller then checks the exit state. hold is the number of extra RELEASE
  // cycles with the sensor still high.
  task automatic run_part(input logic ok, input int hold, input bit pulse_stop);
    bus.part_ok = ok;
    if (ok) begin
      if (m_ok != '1) m_ok = m_ok + 1'b1;
    end else begin
      if (m_rej != '1) m_rej = m_rej + 1'b1;
    end
    exp_q.push_back({m_ok, m_rej, ~ok});
    bus.sensor = 1'b1;
    step(); check("align_a", bus.state, S_ALIGN); check("motor_align", bus.motor_on, 1);
    step(); check("align_b", bus.state, S_ALIGN);
    for (int i = 0; i < 4; i++) begin
      step();
      check("process", bus.state, S_PROCESS);
      check("tool_on_proc", bus.tool_on, 1);
      check("motor_off_proc", bus.motor_on, 0);
      bus.stop = (pulse_stop && i == 0);
    end
    step();
    check("release", bus.state, S_RELEASE);
    check("motor_release", bus.motor_on, 1);
    check("tool_off_release", bus.tool_on, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("release_hold", bus.state, S_RELEASE);
      check("motor_hold", bus.motor_on, 1);
      check("eject_one_cycle", bus.eject, 0);
    end
    bus.sensor = 1'b0;
    step();
    check("eject_after_exit", bus.eject, 0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.sensor  = 1'b0;
    bus.part_ok = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_state", bus.state, S_IDLE);
    check("rst_motor", bus.motor_on, 0);
    check("rst_tool", bus.tool_on, 0);
    check("rst_eject", bus.eject, 0);
    check("rst_done", bus.batch_done, 0);
    check("rst_cnt_ok", bus.count_ok, 0);
    check("rst_cnt_rej", bus.count_rej, 0);

    // Start, then a good part: the exact phase timing is checked inside run_part.
    reset     = 1'b0;
    bus.start = 1'b1;
    step(); check("start_run", bus.state, S_RUN); check("motor_run", bus.motor_on, 1);
    bus.start = 1'b0;
    step(); check("run_wait", bus.state, S_RUN);
    run_part(1'b1, 0, 1'b0);
    check("part1_back_run", bus.state, S_RUN);
    check("part1_cnt_ok", bus.count_ok, 1);

    // Reject with a held sensor: one-cycle eject, and count_ok is unchanged.
    run_part(1'b0, 1, 1'b0);
    check("rej_back_run", bus.state, S_RUN);
    check("rej_cnt_rej", bus.count_rej, 1);
    check("rej_cnt_ok", bus.count_ok, 1);

    // Sensor held through five RELEASE cycles: no extra count.
    run_part(1'b1, 4, 1'b0);
    check("hold_back_run", bus.state, S_RUN);
    check("hold_cnt_ok", bus.count_ok, 2);

    // Third good part completes the batch.
    run_part(1'b1, 0, 1'b0);
    check("batch_done_state", bus.state, S_DONE);
    check("batch_done", bus.batch_done, 1);
    check("done_motor_off", bus.motor_on, 0);
    check("done_cnt_ok", bus.count_ok, 3);
    check("done_cnt_rej", bus.count_rej, 1);
    step(); check("done_stays", bus.state, S_DONE);

    // Start from DONE clears the counters.
    bus.start = 1'b1;
    step();
    check("restart_run", bus.state, S_RUN);
    check("restart_cnt_ok", bus.count_ok, 0);
    check("restart_cnt_rej", bus.count_rej, 0);
    bus.start = 1'b0;
    m_ok  = '0;
    m_rej = '0;

    // A stop pulse during PROCESS: the part is finished and counted, then the FSM goes to IDLE.
    run_part(1'b1, 1, 1'b1);
    check("stop_pend_idle", bus.state, S_IDLE);
    check("stop_pend_cnt", bus.count_ok, 1);

    // start and stop together in IDLE: stop wins.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(); check("start_stop_idle", bus.state, S_IDLE);
    bus.stop = 1'b0;
    step(); check("idle_to_run", bus.state, S_RUN);
    check("idle_run_keeps_cnt", bus.count_ok, 1);
    bus.start = 1'b0;

    // A sensor that is already high when RUN is entered is not a new part.
    bus.stop = 1'b1;
    step(); check("stop_in_run", bus.state, S_IDLE);
    bus.stop   = 1'b0;
    bus.sensor = 1'b1;
    step();
    bus.start = 1'b1;
    step(); check("run_sensor_high", bus.state, S_RUN);
    bus.start = 1'b0;
    repeat (2) step();
    check("no_false_part", bus.state, S_RUN);
    bus.sensor = 1'b0;
    step(); check("run_after_low", bus.state, S_RUN);

    // Reset while in PROCESS.
    bus.sensor = 1'b1;
    step(); step(); step();
    check("pre_reset_proc", bus.state, S_PROCESS);
    reset = 1'b1;
    step();
    check("midrst_state", bus.state, S_IDLE);
    check("midrst_motor", bus.motor_on, 0);
    check("midrst_tool", bus.tool_on, 0);
    check("midrst_cnt_ok", bus.count_ok, 0);
    reset      = 1'b0;
    bus.sensor = 1'b0;
    m_ok  = '0;
    m_rej = '0;

    // 256 rejects: count_rej saturates at 255.
    bus.start = 1'b1;
    step(); check("sat_start", bus.state, S_RUN);
    bus.start = 1'b0;
    for (int p = 0; p < 256; p++) begin
      run_part(1'b0, 0, 1'b0);
      check("sat_back_run", bus.state, S_RUN);
    end
    check("sat_cnt_rej", bus.count_rej, 255);
    check("sat_cnt_ok", bus.count_ok, 0);

    step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
